game_message_display: RTL

Parametrised seven-segment message sequencer for the whack-a-mole top level; the successor to the two-digit start/finish message driver. It drives an arbitrary number of active-low digits. It shows "St" while idle and blanks during play. On game over it waits a configurable delay, blinks "FI" (or "HI" for a new high score) a configurable number of times, then holds it steady. It sits between the game controller (game_started/game_over/new_high_score) and the board HEX outputs.

---
 rtl/game_message_display.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/game_message_display.sv
// Seven-segment message sequencer: "St" when idle, blank in play, delayed blink then hold of "FI"/"HI" after game over.
// Latency: every output is registered and reflects a decision one clock edge after the inputs are sampled.
// Backpressure: none; level inputs are sampled every cycle, and dropping game_over aborts the sequence on the next edge.
module game_message_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_POS       = 2,
  parameter int CLK_HZ        = 50_000_000,
  parameter int OVER_DELAY_MS = 2000,
  parameter int BLINK_MS      = 250,
  parameter int BLINK_COUNT   = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    game_started,
  input  logic                    game_over,
  input  logic                    new_high_score,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    msg_done,
  output logic                    done_pulse
);

  localparam int DELAY_CYC = CLK_HZ / 1000 * OVER_DELAY_MS;
  localparam int BLINK_CYC = CLK_HZ / 1000 * BLINK_MS;
  localparam int MAX_CYC   = (DELAY_CYC > BLINK_CYC) ? DELAY_CYC : BLINK_CYC;
  localparam int CW        = $clog2(MAX_CYC) + 1;
  // A zero-blink build still needs a legal one-bit pair counter.
  localparam int PW        = (BLINK_COUNT > 0) ? $clog2(BLINK_COUNT + 1) : 1;
  localparam int HW        = 7 * NUM_DIGITS;

  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYC - 1);
  localparam logic [PW-1:0] PAIR_LAST  = PW'((BLINK_COUNT > 0) ? BLINK_COUNT - 1 : 0);

  // Active-low glyphs, segment order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_S     = 7'b0010010;
  localparam logic [6:0] GLYPH_T     = 7'b0000111;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_I     = 7'b1111001;
  localparam logic [6:0] GLYPH_H     = 7'b0001001;

  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("NUM_DIGITS must be at least 2");
  end
  if (MSG_POS < 0 || MSG_POS + 1 >= NUM_DIGITS) begin : g_bad_pos
    $error("MSG_POS+1 must be below NUM_DIGITS");
  end
  if (DELAY_CYC < 1 || BLINK_CYC < 1) begin : g_bad_timing
    $error("delay and blink periods must be at least one cycle");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_WAIT,
    S_BLINK,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pair;
  logic          phase_on;
  logic          sel_hi;

  // Places a two-character message on the message digits, all others blank.
  function automatic logic [HW-1:0] place(input logic [6:0] left, input logic [6:0] right);
    logic [HW-1:0] v;
    v = '1;
    v[7*MSG_POS +: 7]       = right;
    v[7*(MSG_POS+1) +: 7]   = left;
    return v;
  endfunction

  function automatic logic [HW-1:0] end_msg(input logic hi);
    return place(hi ? GLYPH_H : GLYPH_F, GLYPH_I);
  endfunction

  // Sequencer state, counters and registered display outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      hex_out    <= place(GLYPH_S, GLYPH_T);
      msg_done   <= 1'b0;
      done_pulse <= 1'b0;
      cnt        <= '0;
      pair       <= '0;
      phase_on   <= 1'b0;
      sel_hi     <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (!game_over && (state == S_WAIT || state == S_BLINK || state == S_HOLD)) begin
        // Game over withdrawn: abandon the end sequence immediately.
        cnt      <= '0;
        pair     <= '0;
        phase_on <= 1'b0;
        if (game_started) begin
          state    <= S_PLAY;
          hex_out  <= '1;
          msg_done <= 1'b0;
        end else begin
          state    <= S_IDLE;
          hex_out  <= place(GLYPH_S, GLYPH_T);
          msg_done <= 1'b1;
        end
      end else if (game_over && (state == S_IDLE || state == S_PLAY)) begin
        // High-score choice is frozen here for the rest of the sequence.
        state    <= S_WAIT;
        cnt      <= '0;
        sel_hi   <= new_high_score;
        hex_out  <= '1;
        msg_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (game_started) begin
              state    <= S_PLAY;
              hex_out  <= '1;
              msg_done <= 1'b0;
            end else begin
              hex_out  <= place(GLYPH_S, GLYPH_T);
              msg_done <= 1'b1;
            end
          end
          S_PLAY: begin
            if (!game_started) begin
              state    <= S_IDLE;
              hex_out  <= place(GLYPH_S, GLYPH_T);
              msg_done <= 1'b1;
            end else begin
              hex_out  <= '1;
              msg_done <= 1'b0;
            end
          end
          S_WAIT: begin
            if (cnt == DELAY_LAST) begin
              cnt     <= '0;
              hex_out <= end_msg(sel_hi);
              if (BLINK_COUNT == 0) begin
                state      <= S_HOLD;
                msg_done   <= 1'b1;
                done_pulse <= 1'b1;
              end else begin
                state    <= S_BLINK;
                phase_on <= 1'b1;
                pair     <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_BLINK: begin
            if (cnt == BLINK_LAST) begin
              cnt <= '0;
              if (phase_on) begin
                phase_on <= 1'b0;
                hex_out  <= '1;
              end else if (pair == PAIR_LAST) begin
                state      <= S_HOLD;
                hex_out    <= end_msg(sel_hi);
                msg_done   <= 1'b1;
                done_pulse <= 1'b1;
              end else begin
                pair     <= pair + 1'b1;
                phase_on <= 1'b1;
                hex_out  <= end_msg(sel_hi);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HOLD: begin
            hex_out  <= end_msg(sel_hi);
            msg_done <= 1'b1;
          end
          default: begin
            state    <= S_IDLE;
            cnt      <= '0;
            hex_out  <= place(GLYPH_S, GLYPH_T);
            msg_done <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
